// File: rtl/rbus_arb.sv
// Two-master round-robin read arbiter: grants one read at a time, strobes the slave,
// waits RD_LATENCY cycles and returns the captured data to the owning master.
module rbus_arb #(
    parameter int ADDR_WIDTH = 24,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic                  slave_rd,
    output logic [ADDR_WIDTH-1:0] slave_raddr,
    input  logic [31:0]           slave_rdata
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        last_reg;
    logic        owner_reg;
    logic        ready_reg;
    logic [31:0] data_reg;
    logic        rvalid0_reg;
    logic        rvalid1_reg;

    logic        idle_ok;
    logic        gnt0;
    logic        gnt1;

    // ready_reg keeps grants off until the first clock after reset release,
    // so a request held through reset never produces a combinational grant.
    always_comb begin
        idle_ok = ready_reg && (state_reg == IDLE);
        gnt0    = idle_ok && m0_req && (!m1_req || last_reg);
        gnt1    = idle_ok && m1_req && (!m0_req || !last_reg);
    end

    assign m0_gnt      = gnt0;
    assign m1_gnt      = gnt1;
    assign slave_rd    = gnt0 | gnt1;
    assign slave_raddr = gnt0 ? m0_addr : (gnt1 ? m1_addr : '0);
    assign m0_rvalid   = rvalid0_reg;
    assign m1_rvalid   = rvalid1_reg;
    assign m0_rdata    = data_reg;
    assign m1_rdata    = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            last_reg    <= 1'b1;
            owner_reg   <= 1'b0;
            ready_reg   <= 1'b0;
            data_reg    <= 32'd0;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
        end else begin
            ready_reg   <= 1'b1;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state_reg <= WAIT;
                        cnt_reg   <= 3'd1;
                        owner_reg <= gnt1;
                        last_reg  <= gnt1;
                    end
                end
                WAIT: begin
                    if (cnt_reg == LAT) begin
                        data_reg    <= slave_rdata;
                        rvalid0_reg <= !owner_reg;
                        rvalid1_reg <= owner_reg;
                        cnt_reg     <= 3'd0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rbus_arb.sv
// Bench for rbus_arb: three instances (latency 1, 2, 3) with a slave delay-line model;
// expected read returns go into a queue that a per-instance monitor drains on rvalid.
module tb_rbus_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [2:0]  rst_n_v, m0_req_v, m1_req_v, m0_gnt_v, m1_gnt_v;
    logic [2:0]  m0_rvalid_v, m1_rvalid_v, slave_rd_v;
    logic [23:0] m0_addr_a [3];
    logic [23:0] m1_addr_a [3];
    logic [23:0] slave_raddr_a [3];
    logic [31:0] m0_rdata_a [3];
    logic [31:0] m1_rdata_a [3];
    logic [31:0] slave_rdata_a [3];

    typedef struct {
        int          inst;
        int          m;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [31:0] mem_f(input logic [23:0] a);
        return (a == 24'h000010) ? 32'hDEADBEEF : {8'hC0, a};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            rbus_arb #(.ADDR_WIDTH(24), .RD_LATENCY(gi + 1)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n_v[gi]),
                .m0_req     (m0_req_v[gi]),
                .m0_addr    (m0_addr_a[gi]),
                .m0_gnt     (m0_gnt_v[gi]),
                .m0_rvalid  (m0_rvalid_v[gi]),
                .m0_rdata   (m0_rdata_a[gi]),
                .m1_req     (m1_req_v[gi]),
                .m1_addr    (m1_addr_a[gi]),
                .m1_gnt     (m1_gnt_v[gi]),
                .m1_rvalid  (m1_rvalid_v[gi]),
                .m1_rdata   (m1_rdata_a[gi]),
                .slave_rd   (slave_rd_v[gi]),
                .slave_raddr(slave_raddr_a[gi]),
                .slave_rdata(slave_rdata_a[gi])
            );

            // Slave: data is valid only in the cycle exactly gi+1 after the strobe.
            logic [31:0] pipe [4];
            logic [3:0]  vld = 4'd0;
            always @(posedge clk) begin
                vld     <= {vld[2:0], slave_rd_v[gi]};
                pipe[0] <= mem_f(slave_raddr_a[gi]);
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
            assign slave_rdata_a[gi] = vld[gi] ? pipe[gi] : (32'hBAD00000 + 32'(cyc_cnt));

            always @(negedge clk) begin
                exp_t e;
                int   m;
                logic [31:0] d;
                #3;
                if (m0_rvalid_v[gi] || m1_rvalid_v[gi]) begin
                    m = m1_rvalid_v[gi] ? 1 : 0;
                    d = m ? m1_rdata_a[gi] : m0_rdata_a[gi];
                    checks++;
                    $display("rvalid inst=%0d m=%0d data=%h cyc=%0d", gi, m, d, cyc_cnt);
                    if (m0_rvalid_v[gi] && m1_rvalid_v[gi]) begin
                        failures++;
                        $display("FAIL rvalid_both inst=%0d: got both rvalid, required one", gi);
                    end else if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rvalid_unexpected inst=%0d: got m%0d data=%h, required none", gi, m, d);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.inst != gi || e.m != m || e.data !== d || e.cyc != cyc_cnt)
                        begin
                            failures++;
                            $display("FAIL rvalid_match: got inst=%0d m=%0d data=%h cyc=%0d, required inst=%0d m=%0d data=%h cyc=%0d",
                                     gi, m, d, cyc_cnt, e.inst, e.m, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_rd(input int inst, input int m, input logic [31:0] data, input int lat);
        exp_t e;
        e.inst = inst; e.m = m; e.data = data; e.cyc = cyc_cnt + lat + 1;
        exp_q.push_back(e);
        $display("grant inst=%0d m=%0d data_exp=%h due=%0d", inst, m, data, e.cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_v  = 3'b000;
        m0_req_v = 3'b000;
        m1_req_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m0_addr_a[i] = '0;
            m1_addr_a[i] = '0;
        end

        // Reset held with both requests high: everything quiet.
        m0_req_v[0] = 1'b1; m1_req_v[0] = 1'b1;
        m0_addr_a[0] = 24'h000100; m1_addr_a[0] = 24'h000200;
        tick; tick;
        chk("rst_gnt0", 32'(m0_gnt_v[0]), 32'd0);
        chk("rst_gnt1", 32'(m1_gnt_v[0]), 32'd0);
        chk("rst_slave_rd", 32'(slave_rd_v[0]), 32'd0);
        chk("rst_raddr", 32'(slave_raddr_a[0]), 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid_v[0], m1_rvalid_v[0]}), 32'd0);
        chk("rst_rdata", m0_rdata_a[0], 32'd0);
        rst_n_v = 3'b111;

        // Round robin, latency 1: M0, M1, M0, M1 two cycles apart.
        for (int k = 0; k < 8; k++) begin
            tick;
            if (k == 7) begin
                m0_req_v[0] = 1'b0; m1_req_v[0] = 1'b0;
                #1;
            end
            chk($sformatf("rr_gnt0_k%0d", k), 32'(m0_gnt_v[0]), 32'(k % 4 == 0));
            chk($sformatf("rr_gnt1_k%0d", k), 32'(m1_gnt_v[0]), 32'(k % 4 == 2));
            chk($sformatf("rr_raddr_k%0d", k), 32'(slave_raddr_a[0]),
                (k % 4 == 0) ? 32'h100 : ((k % 4 == 2) ? 32'h200 : 32'h0));
            if (k % 4 == 0) expect_rd(0, 0, 32'hC0000100, 1);
            if (k % 4 == 2) expect_rd(0, 1, 32'hC0000200, 1);
        end

        // Single read, latency 1.
        tick;
        m0_req_v[0] = 1'b1; m0_addr_a[0] = 24'h000010;
        #1;
        chk("single_gnt0", 32'(m0_gnt_v[0]), 32'd1);
        chk("single_gnt1", 32'(m1_gnt_v[0]), 32'd0);
        chk("single_slave_rd", 32'(slave_rd_v[0]), 32'd1);
        chk("single_raddr", 32'(slave_raddr_a[0]), 32'h000010);
        expect_rd(0, 0, 32'hDEADBEEF, 1);
        tick;
        m0_req_v[0] = 1'b0;
        tick; tick; tick;
        chk("hold_rdata0", m0_rdata_a[0], 32'hDEADBEEF);
        chk("hold_rdata1", m1_rdata_a[0], 32'hDEADBEEF);

        // Latency 3: M1 read, M0 waits through T+1..T+3, granted at T+4.
        tick;
        m1_req_v[2] = 1'b1; m1_addr_a[2] = 24'h000300;
        #1;
        chk("l3_gnt1", 32'(m1_gnt_v[2]), 32'd1);
        chk("l3_raddr1", 32'(slave_raddr_a[2]), 32'h300);
        expect_rd(2, 1, 32'hC0000300, 3);
        for (int j = 1; j <= 3; j++) begin
            tick;
            if (j == 1) begin
                m1_req_v[2] = 1'b0; m0_req_v[2] = 1'b1; m0_addr_a[2] = 24'h000400;
                #1;
            end
            chk($sformatf("l3_wait_gnt_t%0d", j), 32'({m0_gnt_v[2], m1_gnt_v[2]}), 32'd0);
            chk($sformatf("l3_wait_rd_t%0d", j), 32'(slave_rd_v[2]), 32'd0);
        end
        tick;
        chk("l3_gnt0_t4", 32'(m0_gnt_v[2]), 32'd1);
        chk("l3_raddr0", 32'(slave_raddr_a[2]), 32'h400);
        expect_rd(2, 0, 32'hC0000400, 3);

        // Withdrawn M1 request during WAIT: no grant, pointer stays on M0.
        tick;
        m0_req_v[2] = 1'b0; m1_req_v[2] = 1'b1;
        #1;
        chk("wd_gnt1_a", 32'(m1_gnt_v[2]), 32'd0);
        tick;
        chk("wd_gnt1_b", 32'(m1_gnt_v[2]), 32'd0);
        tick;
        m1_req_v[2] = 1'b0;
        #1;
        chk("wd_gnt1_c", 32'(m1_gnt_v[2]), 32'd0);
        tick;
        chk("wd_idle_gnt", 32'({m0_gnt_v[2], m1_gnt_v[2]}), 32'd0);
        m0_req_v[2] = 1'b1; m1_req_v[2] = 1'b1; m0_addr_a[2] = 24'h000410;
        #1;
        chk("wd_tie_gnt1", 32'(m1_gnt_v[2]), 32'd1);
        chk("wd_tie_gnt0", 32'(m0_gnt_v[2]), 32'd0);
        chk("wd_tie_raddr", 32'(slave_raddr_a[2]), 32'h300);
        expect_rd(2, 1, 32'hC0000300, 3);
        tick;
        m0_req_v[2] = 1'b0; m1_req_v[2] = 1'b0;
        repeat (5) tick;

        // Reset mid-read, latency 2: read dropped, register stays 0.
        m0_req_v[1] = 1'b1; m0_addr_a[1] = 24'h000500;
        #1;
        chk("mr_gnt0", 32'(m0_gnt_v[1]), 32'd1);
        tick;
        m0_req_v[1] = 1'b0; rst_n_v[1] = 1'b0;
        #1;
        chk("mr_rvalid", 32'({m0_rvalid_v[1], m1_rvalid_v[1]}), 32'd0);
        tick; tick;
        rst_n_v[1] = 1'b1;
        repeat (4) tick;
        chk("mr_rdata", m0_rdata_a[1], 32'd0);
        chk("mr_gnt_idle", 32'({m0_gnt_v[1], m1_gnt_v[1]}), 32'd0);

        repeat (3) tick;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rbus_arb.md
# rbus_arb

Two-master read arbiter and sequencer for the data-memory read bus. It sits between two read requesters and one slave read port produced by the address decoder: master 0 is the CPU data port and master 1 is the display/refresh engine. It grants one read at a time using round-robin arbitration. It drives the slave strobe and address, waits a fixed slave latency, then returns registered read data to the granted master.

## Interface
- `ADDR_WIDTH`, default 24: width of the slave read address.
- `RD_LATENCY`, default 1: cycles from the `slave_rd` strobe to valid `slave_rdata`. Legal range is 1..4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  master 0 read request; level signal, held until `m0_gnt`.
- `m0_addr`  in  ADDR_WIDTH  master 0 read address; stable while `m0_req`=1.
- `m0_gnt`  out  1  one-cycle grant to master 0.
- `m0_rvalid`  out  1  one-cycle pulse: `m0_rdata` holds the result of master 0's read.
- `m0_rdata`  out  32  read data register (shared with `m1_rdata`).
- `m1_req`, `m1_addr`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as master 0.
- `slave_rd`  out  1  one-cycle read strobe to the slave.
- `slave_raddr`  out  ADDR_WIDTH  address of the granted master; zero when `slave_rd`=0.
- `slave_rdata`  in  32  slave read data; valid exactly `RD_LATENCY` cycles after `slave_rd`.

## Operation
- FSM states:
  - IDLE: no read outstanding.
  - WAIT: one read outstanding; latency counter `cnt` (3 bits) running.
- IDLE with any `req`=1:
  - Combinationally select the winner and assert `mX_gnt`=1, `slave_rd`=1, `slave_raddr`=`mX_addr` in the same cycle.
  - Next state is WAIT with `cnt`=1. Record the owner and update the round-robin pointer `last`=X.
- Arbitration:
  - A single requester always wins.
  - If both request, the master not equal to `last` wins.
  - `last` resets to 1, so master 0 wins the first tie.
- WAIT:
  - While `cnt`<`RD_LATENCY`: `cnt`++.
  - When `cnt`==`RD_LATENCY`: capture `slave_rdata` into the data register, set the owner's `rvalid` flop, and return to IDLE.
- `rvalid` flops are set for exactly one cycle. The data register holds its value until the next capture.
- IDLE is the only state that grants. There is at most one outstanding read, so no `gnt` or `slave_rd` is issued in WAIT.
- Requests arriving during WAIT are held by the masters and arbitrated on the return to IDLE.
- A master deasserting `req` before grant is legal. It is simply not granted, and no state changes.
- `m0_rdata` and `m1_rdata` both drive the shared register. Only the owner's `rvalid` qualifies it.

## Timing
- Reset (async assert, sync-safe release):
  - state=IDLE, `cnt`=0, `last`=1, data register=0, both `rvalid`=0.
  - `gnt`/`slave_rd` are 0 because no request is sampled during reset; `slave_raddr`=0.
- A grant in cycle T gives:
  - `slave_rd` in T;
  - `slave_rdata` sampled at the end of T+`RD_LATENCY`;
  - `mX_rvalid`=1 in T+`RD_LATENCY`+1.
- Back-to-back: the next grant may occur in cycle T+`RD_LATENCY`+1, the same cycle as the previous `rvalid`. Peak throughput is one read per `RD_LATENCY`+1 cycles.
- Reset asserted mid-read:
  - The outstanding read is dropped and no `rvalid` is issued.
  - Slave data returned after reset is ignored.
- Simultaneous `m0_req`/`m1_req` in IDLE: exactly one `gnt`, never both.
- `slave_raddr` is forced to 0 when not granting, to ease bus observation.

## Test plan
- **Reset:** with reset held and both `req`=1, all outputs are 0; after release, master 0 is granted first (`last`=1).
- **Single read (`RD_LATENCY`=1):**
  - Stimulus: `m0_req`=1, `m0_addr`=0x00_0010; slave returns 0xDEAD_BEEF at T+1.
  - Response: `m0_gnt`/`slave_rd`/`slave_raddr`=0x000010 at T; `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF at T+2; `m1_rvalid` stays 0.
- **Round-robin contention:** both `req` held high for 4 reads; grants alternate M0, M1, M0, M1, spaced 2 cycles apart; each `rvalid` goes to the matching master with the matching data.
- **`RD_LATENCY`=3:**
  - Stimulus: `m1` read at T.
  - Response: `slave_rdata` is sampled at T+3 only, and values at T+1..T+2 are ignored; `m1_rvalid` at T+4; no grant during T+1..T+3 despite `m0_req`=1; `m0_gnt` at T+4.
- **Reset mid-read:** `rst_n`=0 at T+1 of a `RD_LATENCY`=2 read; no `rvalid` ever pulses for that read, and the data register reads 0.
- **Request withdrawn:** `m1_req` pulses during WAIT and drops before IDLE; no `m1_gnt`, and the pointer is unchanged.
